// File: rtl/present_ctr_sequencer_if.sv
// Keystream sequencer links: output stream toward the consumer (valid/ready) and
// the start/ready link to the serial PRESENT core. master = sequencer side.
interface present_ctr_sequencer_if #(
   parameter int NB_W = 8
);
   logic [63:0]     Out_ob;
   logic [NB_W-1:0] OutIndex_ob;
   logic            OutValid_o;
   logic            OutReady_i;
   logic [63:0]     CorePlainText_ob;
   logic            CoreStart_o;
   logic            CoreReady_i;
   logic [63:0]     CoreCipherText_ib;

   modport master (
      output Out_ob, OutIndex_ob, OutValid_o, CorePlainText_ob, CoreStart_o,
      input  OutReady_i, CoreReady_i, CoreCipherText_ib
   );

   modport slave (
      input  Out_ob, OutIndex_ob, OutValid_o, CorePlainText_ob, CoreStart_o,
      output OutReady_i, CoreReady_i, CoreCipherText_ib
   );
endinterface

// File: rtl/present_ctr_sequencer.sv
// Counter-mode keystream sequencer around the serial PRESENT core: one block per core latency + 3 cycles.
// One-deep output buffer; a stalled consumer lets the next block compute but holds it in the core until the buffer frees.
module present_ctr_sequencer #(
   parameter int CNT_W = 32,
   parameter int NB_W  = 8
) (
   input  logic                   Clk_ik,
   input  logic                   Reset_ir,
   input  logic [63-CNT_W:0]      Nonce_ib,
   input  logic [CNT_W-1:0]       InitCnt_ib,
   input  logic [NB_W-1:0]        NumBlocks_ib,
   input  logic                   Go_i,
   input  logic                   Abort_i,
   output logic                   Busy_o,
   output logic                   Done_o,
   output logic                   CntWrap_o,
   present_ctr_sequencer_if.master bus
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT, DRAIN, FLUSH} state_t;

   state_t            state;
   logic [63-CNT_W:0] nonce;
   logic [CNT_W-1:0]  cnt;
   logic [NB_W-1:0]   remaining;
   logic [NB_W-1:0]   issue_idx;
   logic              core_guard;
   logic              out_fire;
   logic              buf_free;
   logic              core_done;

   assign out_fire  = bus.OutValid_o & bus.OutReady_i;
   assign buf_free  = ~bus.OutValid_o | bus.OutReady_i;
   // The core may still show Ready in the cycle after it sees Start, so that cycle is masked.
   assign core_done = bus.CoreReady_i & ~core_guard;

   always_ff @(posedge Clk_ik) begin
      if (Reset_ir) begin
         state                <= IDLE;
         nonce                <= '0;
         cnt                  <= '0;
         remaining            <= '0;
         issue_idx            <= '0;
         core_guard           <= 1'b0;
         Busy_o               <= 1'b0;
         Done_o               <= 1'b0;
         CntWrap_o            <= 1'b0;
         bus.Out_ob           <= '0;
         bus.OutIndex_ob      <= '0;
         bus.OutValid_o       <= 1'b0;
         bus.CorePlainText_ob <= '0;
         bus.CoreStart_o      <= 1'b0;
      end else begin
         Done_o          <= 1'b0;
         bus.CoreStart_o <= 1'b0;
         core_guard      <= 1'b0;
         if (out_fire)
            bus.OutValid_o <= 1'b0;

         case (state)
            IDLE: begin
               if (Go_i) begin
                  if (NumBlocks_ib == '0) begin
                     Done_o <= 1'b1;
                  end else begin
                     nonce     <= Nonce_ib;
                     cnt       <= InitCnt_ib;
                     remaining <= NumBlocks_ib;
                     issue_idx <= '0;
                     CntWrap_o <= 1'b0;
                     Busy_o    <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               if (Abort_i) begin
                  bus.OutValid_o <= 1'b0;
                  Busy_o         <= 1'b0;
                  state          <= IDLE;
               end else if (bus.CoreReady_i) begin
                  bus.CoreStart_o      <= 1'b1;
                  bus.CorePlainText_ob <= {nonce, cnt};
                  state                <= WAIT1;
               end
            end

            WAIT1: begin
               core_guard <= 1'b1;
               if (Abort_i) begin
                  bus.OutValid_o <= 1'b0;
                  state          <= FLUSH;
               end else begin
                  state <= WAIT;
               end
            end

            WAIT: begin
               if (Abort_i) begin
                  bus.OutValid_o <= 1'b0;
                  core_guard     <= 1'b1;
                  state          <= FLUSH;
               end else if (core_done && buf_free) begin
                  bus.Out_ob      <= bus.CoreCipherText_ib;
                  bus.OutIndex_ob <= issue_idx;
                  bus.OutValid_o  <= 1'b1;
                  cnt             <= cnt + 1'b1;
                  if (&cnt)
                     CntWrap_o <= 1'b1;
                  issue_idx <= issue_idx + 1'b1;
                  remaining <= remaining - 1'b1;
                  state     <= (remaining > NB_W'(1)) ? ISSUE : DRAIN;
               end
            end

            DRAIN: begin
               if (Abort_i) begin
                  bus.OutValid_o <= 1'b0;
                  Busy_o         <= 1'b0;
                  state          <= IDLE;
               end else if (out_fire) begin
                  Done_o <= 1'b1;
                  Busy_o <= 1'b0;
                  state  <= IDLE;
               end
            end

            // Swallow the result of the abandoned core operation before accepting new work.
            FLUSH: begin
               if (core_done) begin
                  Busy_o <= 1'b0;
                  state  <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_present_ctr_sequencer.sv
// Directed bench for present_ctr_sequencer with a 32-cycle XOR stand-in for the PRESENT core.
module tb_present_ctr_sequencer;
   localparam int          CNT_W = 32;
   localparam int          NB_W  = 8;
   localparam int          LAT   = 32;
   localparam logic [63:0] KEY   = 64'hA5A5_5A5A_0F0F_F0F0;

   logic              Clk_ik = 1'b0;
   logic              Reset_ir;
   logic [63-CNT_W:0] Nonce_ib;
   logic [CNT_W-1:0]  InitCnt_ib;
   logic [NB_W-1:0]   NumBlocks_ib;
   logic              Go_i;
   logic              Abort_i;
   logic              Busy_o;
   logic              Done_o;
   logic              CntWrap_o;

   int total = 0;
   int bad   = 0;

   int          cyc       = 0;
   int          core_cnt  = 0;
   int          done_cnt  = 0;
   int          busy_cyc  = 0;
   int          proto_err = 0;
   int          acc_cyc   = 0;
   int          done_cyc  = 0;
   logic [63:0] core_pt   = '0;
   logic [63:0]     start_q[$];
   logic [63:0]     out_q[$];
   logic [NB_W-1:0] idx_q[$];

   present_ctr_sequencer_if #(.NB_W(NB_W)) sif();

   present_ctr_sequencer #(.CNT_W(CNT_W), .NB_W(NB_W)) dut (
      .Clk_ik       (Clk_ik),
      .Reset_ir     (Reset_ir),
      .Nonce_ib     (Nonce_ib),
      .InitCnt_ib   (InitCnt_ib),
      .NumBlocks_ib (NumBlocks_ib),
      .Go_i         (Go_i),
      .Abort_i      (Abort_i),
      .Busy_o       (Busy_o),
      .Done_o       (Done_o),
      .CntWrap_o    (CntWrap_o),
      .bus          (sif)
   );

   always #5 Clk_ik = ~Clk_ik;

   assign sif.CoreReady_i       = (core_cnt == 0);
   assign sif.CoreCipherText_ib = core_pt ^ KEY;

   // Core model plus event recorders; the core is never reset.
   always @(posedge Clk_ik) begin
      cyc <= cyc + 1;
      if (sif.CoreStart_o) begin
         start_q.push_back(sif.CorePlainText_ob);
         if (core_cnt != 0)
            proto_err <= proto_err + 1;
         core_cnt <= LAT;
         core_pt  <= sif.CorePlainText_ob;
      end else if (core_cnt != 0) begin
         core_cnt <= core_cnt - 1;
      end
      if (sif.OutValid_o && sif.OutReady_i) begin
         out_q.push_back(sif.Out_ob);
         idx_q.push_back(sif.OutIndex_ob);
         acc_cyc <= cyc;
      end
      if (Done_o) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (Busy_o)
         busy_cyc <= busy_cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk_ik);
      #1;
   endtask

   task automatic go(input logic [31:0] n, input logic [31:0] c, input logic [7:0] nb);
      Nonce_ib     = n;
      InitCnt_ib   = c;
      NumBlocks_ib = nb;
      Go_i         = 1'b1;
      tick();
      Go_i         = 1'b0;
   endtask

   // Returns one cycle after Done_o so the recorders have seen the pulse.
   task automatic wait_done(input string tag, input int max);
      int n = 0;
      while (!Done_o && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, 64'(Done_o), 64'd1);
      tick();
   endtask

   task automatic wait_starts(input string tag, input int target, input int max);
      int n = 0;
      while (start_q.size() < target && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_starts"}, 64'(start_q.size()), 64'(target));
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"},  64'(Busy_o), 64'd0);
      chk({tag, "_done"},  64'(Done_o), 64'd0);
      chk({tag, "_wrap"},  64'(CntWrap_o), 64'd0);
      chk({tag, "_oval"},  64'(sif.OutValid_o), 64'd0);
      chk({tag, "_out"},   sif.Out_ob, 64'd0);
      chk({tag, "_oidx"},  64'(sif.OutIndex_ob), 64'd0);
      chk({tag, "_pt"},    sif.CorePlainText_ob, 64'd0);
      chk({tag, "_start"}, 64'(sif.CoreStart_o), 64'd0);
   endtask

   initial begin
      int          bs, bo, bd, bb, n;
      bit          have, unstable;
      logic [63:0] snap, exp_pt;
      logic [7:0]  sidx;

      Reset_ir       = 1'b1;
      Nonce_ib       = '0;
      InitCnt_ib     = '0;
      NumBlocks_ib   = '0;
      Go_i           = 1'b0;
      Abort_i        = 1'b0;
      sif.OutReady_i = 1'b0;
      repeat (3) tick();
      chk_outputs_zero("rst");
      Reset_ir = 1'b0;
      tick();

      // single block
      sif.OutReady_i = 1'b1;
      bs = start_q.size(); bo = out_q.size(); bd = done_cnt;
      go(32'h1234_5678, 32'h0, 8'd1);
      chk("t1_busy", 64'(Busy_o), 64'd1);
      wait_done("t1", 200);
      chk("t1_nstart", 64'(start_q.size() - bs), 64'd1);
      chk("t1_pt",     start_q[bs], 64'h1234_5678_0000_0000);
      chk("t1_nout",   64'(out_q.size() - bo), 64'd1);
      chk("t1_ct",     out_q[bo], 64'hB791_0C22_0F0F_F0F0);
      chk("t1_idx",    64'(idx_q[bo]), 64'd0);
      chk("t1_ndone",  64'(done_cnt - bd), 64'd1);
      chk("t1_donelat", 64'(done_cyc - acc_cyc), 64'd1);
      chk("t1_idle",   64'(Busy_o), 64'd0);

      // three blocks, no backpressure
      bs = start_q.size(); bo = out_q.size(); bd = done_cnt;
      go(32'hCAFE_F00D, 32'd5, 8'd3);
      wait_done("t2", 400);
      chk("t2_nstart", 64'(start_q.size() - bs), 64'd3);
      chk("t2_nout",   64'(out_q.size() - bo), 64'd3);
      for (int i = 0; i < 3; i++) begin
         exp_pt = {32'hCAFE_F00D, 32'(5 + i)};
         chk("t2_pt",  start_q[bs + i], exp_pt);
         chk("t2_ct",  out_q[bo + i], exp_pt ^ KEY);
         chk("t2_idx", 64'(idx_q[bo + i]), 64'(i));
      end
      chk("t2_ndone", 64'(done_cnt - bd), 64'd1);
      chk("t2_wrap",  64'(CntWrap_o), 64'd0);

      // backpressure: consumer stalls for 100 cycles
      sif.OutReady_i = 1'b0;
      bs = start_q.size(); bo = out_q.size(); bd = done_cnt;
      have = 1'b0; unstable = 1'b0; snap = '0; sidx = '0;
      go(32'h0BAD_CAFE, 32'd100, 8'd3);
      for (int i = 0; i < 100; i++) begin
         if (!have && sif.OutValid_o) begin
            have = 1'b1;
            snap = sif.Out_ob;
            sidx = sif.OutIndex_ob;
         end else if (have && (!sif.OutValid_o || sif.Out_ob != snap || sif.OutIndex_ob != sidx)) begin
            unstable = 1'b1;
         end
         tick();
      end
      chk("t3_held",   64'(have), 64'd1);
      chk("t3_blk0",   snap, {32'h0BAD_CAFE, 32'd100} ^ KEY);
      chk("t3_idx0",   64'(sidx), 64'd0);
      chk("t3_stable", 64'(unstable), 64'd0);
      chk("t3_nstart", 64'(start_q.size() - bs), 64'd2);
      chk("t3_nout",   64'(out_q.size() - bo), 64'd0);
      sif.OutReady_i = 1'b1;
      wait_done("t3", 400);
      chk("t3_nout2",  64'(out_q.size() - bo), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk("t3_ct",  out_q[bo + i], {32'h0BAD_CAFE, 32'(100 + i)} ^ KEY);
         chk("t3_idx", 64'(idx_q[bo + i]), 64'(i));
      end
      chk("t3_ndone", 64'(done_cnt - bd), 64'd1);

      // counter wrap, then cleared by the next Go
      bs = start_q.size();
      go(32'h0000_0001, 32'hFFFF_FFFF, 8'd2);
      wait_done("t4", 300);
      chk("t4_pt0",  start_q[bs],     64'h0000_0001_FFFF_FFFF);
      chk("t4_pt1",  start_q[bs + 1], 64'h0000_0001_0000_0000);
      chk("t4_wrap", 64'(CntWrap_o), 64'd1);
      go(32'h0000_0002, 32'h0, 8'd1);
      chk("t4_wrapclr", 64'(CntWrap_o), 64'd0);
      wait_done("t4b", 200);

      // abort in WAIT of block 1 of 4, block 0 still held
      sif.OutReady_i = 1'b0;
      bs = start_q.size(); bo = out_q.size(); bd = done_cnt;
      go(32'h5555_AAAA, 32'h10, 8'd4);
      wait_starts("t5", bs + 2, 200);
      repeat (3) tick();
      chk("t5_preval", 64'(sif.OutValid_o), 64'd1);
      Abort_i = 1'b1;
      tick();
      Abort_i = 1'b0;
      chk("t5_oval", 64'(sif.OutValid_o), 64'd0);
      chk("t5_busy", 64'(Busy_o), 64'd1);
      n = 0;
      while (Busy_o && n < 100) begin
         tick();
         n++;
      end
      chk("t5_idle",    64'(Busy_o), 64'd0);
      chk("t5_coreabs", 64'(sif.CoreReady_i), 64'd1);
      repeat (3) tick();
      chk("t5_nstart", 64'(start_q.size() - bs), 64'd2);
      chk("t5_ndone",  64'(done_cnt - bd), 64'd0);
      chk("t5_nout",   64'(out_q.size() - bo), 64'd0);
      sif.OutReady_i = 1'b1;
      bo = out_q.size();
      go(32'h7777_0000, 32'h42, 8'd1);
      wait_done("t5b", 200);
      chk("t5b_ct",  out_q[bo], {32'h7777_0000, 32'h42} ^ KEY);
      chk("t5b_idx", 64'(idx_q[bo]), 64'd0);

      // zero blocks
      bs = start_q.size(); bd = done_cnt; bb = busy_cyc;
      go(32'h1111_1111, 32'h1, 8'd0);
      chk("t6_done", 64'(Done_o), 64'd1);
      tick();
      chk("t6_done1", 64'(Done_o), 64'd0);
      repeat (3) tick();
      chk("t6_busy",   64'(busy_cyc - bb), 64'd0);
      chk("t6_nstart", 64'(start_q.size() - bs), 64'd0);
      chk("t6_ndone",  64'(done_cnt - bd), 64'd1);

      // reset mid-WAIT with block 0 held, then a fresh job behind the running core
      sif.OutReady_i = 1'b0;
      bs = start_q.size();
      go(32'h9999_0000, 32'h0, 8'd2);
      wait_starts("t7", bs + 2, 200);
      repeat (3) tick();
      chk("t7_preval", 64'(sif.OutValid_o), 64'd1);
      Reset_ir = 1'b1;
      tick();
      chk_outputs_zero("t7rst");
      Reset_ir = 1'b0;
      tick();
      sif.OutReady_i = 1'b1;
      bo = out_q.size();
      go(32'hABCD_0000, 32'h3, 8'd1);
      wait_done("t7b", 200);
      chk("t7b_ct", out_q[bo], {32'hABCD_0000, 32'h3} ^ KEY);

      chk("proto", 64'(proto_err), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
